ttl_inv_bank: RTL and testbench



---
 rtl/ttl_inv_bank.sv | 115 +++++++++++
 tb/tb_ttl_inv_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ttl_inv_bank.sv
// Clocked 7404/05/06/07-style inverter/buffer bank: per-channel input glitch filter,
// invert-or-buffer function, clock-enabled delay pipeline and open-collector emulation.
module ttl_inv_bank #(
    parameter int CHANNELS    = 6,
    parameter     INVERT_MASK = {CHANNELS{1'b1}},
    parameter     OC_MASK     = {CHANNELS{1'b0}},
    parameter int DELAY       = 1,
    parameter int FILTER      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] y_oe
);

    localparam logic [CHANNELS-1:0] INV_M = INVERT_MASK;
    localparam logic [CHANNELS-1:0] OC_M  = OC_MASK;
    localparam int                  CW    = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("ttl_inv_bank: CHANNELS must be 1..32");
        end
        if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
            $error("ttl_inv_bank: DELAY must be 0..15");
        end
        if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
            $error("ttl_inv_bank: FILTER must be 0..255");
        end
        if ($bits(INVERT_MASK) != CHANNELS) begin : g_bad_inv_mask
            $error("ttl_inv_bank: INVERT_MASK width must equal CHANNELS");
        end
        if ($bits(OC_MASK) != CHANNELS) begin : g_bad_oc_mask
            $error("ttl_inv_bank: OC_MASK width must equal CHANNELS");
        end
    endgenerate

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] f;
    logic [CHANNELS-1:0] p;

    genvar gi;
    generate
        if (FILTER == 0) begin : g_no_filter
            assign s = a;
        end else begin : g_filter
            // The edge on which cnt would reach FILTER is the accepting edge.
            localparam logic [CW-1:0] FILT_LAST = CW'(FILTER - 1);
            for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
                logic          s_q;
                logic          s_d;
                logic [CW-1:0] cnt_q;
                logic [CW-1:0] cnt_d;

                always_comb begin
                    s_d   = s_q;
                    cnt_d = cnt_q;
                    if (a[gi] == s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == FILT_LAST) begin
                        s_d   = a[gi];
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s_q   <= 1'b0;
                        cnt_q <= '0;
                    end else if (ce) begin
                        s_q   <= s_d;
                        cnt_q <= cnt_d;
                    end
                end

                assign s[gi] = s_q;
            end
        end
    endgenerate

    assign f = s ^ INV_M;

    generate
        if (DELAY == 0) begin : g_no_pipe
            assign p = f;
        end else begin : g_pipe
            logic [CHANNELS-1:0] pipe_q [DELAY];

            // Reset loads the function of a=0 so the outputs start glitch-free.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DELAY; k++) begin
                        pipe_q[k] <= INV_M;
                    end
                end else if (ce) begin
                    pipe_q[0] <= f;
                    for (int k = 1; k < DELAY; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign p = pipe_q[DELAY-1];
        end
    endgenerate

    // Open-collector channels read back high through the emulated pull-up when released.
    assign y    = p;
    assign y_oe = ~OC_M | ~p;

endmodule

// File: tb/tb_ttl_inv_bank.sv
// Directed bench for ttl_inv_bank: several parameterisations share clk/rst/ce,
// each driven and checked at hand-computed points.
module tb_ttl_inv_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    logic [5:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic [0:0] a5 = '0;
    logic [5:0] y0, y1, y2, y3, y4, oe0, oe1, oe2, oe3, oe4;
    logic [0:0] y5, oe5;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ttl_inv_bank u0 (.clk(clk), .rst(rst), .ce(ce), .a(a0), .y(y0), .y_oe(oe0));

    ttl_inv_bank #(.INVERT_MASK(6'b000111), .OC_MASK(6'b111000), .DELAY(0)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .a(a1), .y(y1), .y_oe(oe1));

    ttl_inv_bank #(.FILTER(3), .DELAY(1)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .a(a2), .y(y2), .y_oe(oe2));

    ttl_inv_bank #(.DELAY(4)) u3 (
        .clk(clk), .rst(rst), .ce(ce), .a(a3), .y(y3), .y_oe(oe3));

    ttl_inv_bank #(.FILTER(2), .DELAY(3)) u4 (
        .clk(clk), .rst(rst), .ce(ce), .a(a4), .y(y4), .y_oe(oe4));

    ttl_inv_bank #(.CHANNELS(1), .INVERT_MASK(1'b0), .OC_MASK(1'b1), .DELAY(1)) u5 (
        .clk(clk), .rst(rst), .ce(ce), .a(a5), .y(y5), .y_oe(oe5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("t=%0t %-14s observed=%h expected=%h", $time, tag, obs, exp);
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with all inputs low.
        step();
        step();
        rst = 1'b0;
        chk("rst_u0_y",   y0,  32'h3F);
        chk("rst_u0_oe",  oe0, 32'h3F);
        chk("rst_u1_y",   y1,  32'h07);
        chk("rst_u1_oe",  oe1, 32'h3F);
        chk("rst_u2_y",   y2,  32'h3F);
        chk("rst_u4_y",   y4,  32'h3F);
        chk("rst_u5_y",   y5,  32'h0);
        chk("rst_u5_oe",  oe5, 32'h1);

        // Defaults: one-cycle inverter.
        a0 = 6'h15;
        #1;
        chk("u0_pre_edge", y0, 32'h3F);
        step();
        chk("u0_after",    y0, 32'h2A);
        chk("u0_oe",       oe0, 32'h3F);

        // Mixed masks, fully combinational.
        a1 = 6'h3F;
        #1;
        chk("u1_a3f_y",  y1,  32'h38);
        chk("u1_a3f_oe", oe1, 32'h07);
        a1 = 6'h00;
        #1;
        chk("u1_a00_y",  y1,  32'h07);
        chk("u1_a00_oe", oe1, 32'h3F);

        // 7407 emulation.
        a5 = 1'b1;
        #1;
        chk("u5_pre_edge", y5, 32'h0);
        step();
        chk("u5_hi_y",  y5,  32'h1);
        chk("u5_hi_oe", oe5, 32'h0);
        a5 = 1'b0;
        step();
        chk("u5_lo_y",  y5,  32'h0);
        chk("u5_lo_oe", oe5, 32'h1);

        // Filter: a 2-cycle pulse is rejected.
        a2 = 6'h01;
        step();
        step();
        a2 = 6'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("u2_glitch", {31'b0, y2[0]}, 32'h1);
        end

        // Filter: a 3-cycle pulse is accepted; y falls on the 4th edge.
        a2 = 6'h01;
        step();
        chk("u2_e1", {31'b0, y2[0]}, 32'h1);
        step();
        chk("u2_e2", {31'b0, y2[0]}, 32'h1);
        step();
        chk("u2_e3", {31'b0, y2[0]}, 32'h1);
        a2 = 6'h00;
        step();
        chk("u2_e4_fall", {31'b0, y2[0]}, 32'h0);
        chk("u2_oth_bits", y2, 32'h3E);
        step();
        chk("u2_e5", {31'b0, y2[0]}, 32'h0);
        step();
        chk("u2_e6", {31'b0, y2[0]}, 32'h0);
        step();
        chk("u2_e7_rise", {31'b0, y2[0]}, 32'h1);

        // Delay pipeline stretched by disabled cycles.
        a3 = 6'h04;
        step();
        chk("u3_e1", y3, 32'h3F);
        step();
        chk("u3_e2", y3, 32'h3F);
        ce = 1'b0;
        a0 = 6'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("u3_frozen", y3, 32'h3F);
            chk("u0_frozen", y0, 32'h2A);
        end
        ce = 1'b1;
        step();
        chk("u3_e3", y3, 32'h3F);
        chk("u0_resume", y0, 32'h3F);
        step();
        chk("u3_e4", y3, 32'h3B);

        // Asynchronous reset discards an in-flight change.
        a4 = 6'h3F;
        step();
        step();
        step();
        step();
        chk("u4_inflight", y4, 32'h3F);
        rst = 1'b1;
        a4  = 6'h00;
        #1;
        chk("u4_async_y",  y4,  32'h3F);
        chk("u4_async_oe", oe4, 32'h3F);
        chk("u3_async_y",  y3,  32'h3F);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("u4_discard", y4, 32'h3F);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
